// File: rtl/dsp_addsub_bist_pkg.sv
// ----------------------------------------------------------------------------
// dsp_addsub_bist_pkg
//   Shared definitions for the dsp_add_sub built-in self-test:
//   - op encoding shared with dsp_add_sub (OP_ADD / OP_SUB)
//   - Galois LFSR tap mask and single-step helper
//   - BIST sequencer state encoding
//   - 4-entry directed corner-case vector table
// ----------------------------------------------------------------------------
package dsp_addsub_bist_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_SETTLE,
      ST_CHECK,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        op;
   } vec_t;

   // Carry/borrow wrap corners of the 32-bit adder/subtractor.
   function automatic vec_t directed_vec(input logic [1:0] sel);
      vec_t v;
      case (sel)
         2'd0:    v = '{a: 32'hFFFF_FFFF, b: 32'h0000_0001, op: OP_ADD};
         2'd1:    v = '{a: 32'h0000_0000, b: 32'h0000_0001, op: OP_SUB};
         2'd2:    v = '{a: 32'h7FFF_FFFF, b: 32'h0000_0001, op: OP_ADD};
         default: v = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, op: OP_SUB};
      endcase
      return v;
   endfunction

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/dsp_addsub_bist_lfsr32.sv
// ----------------------------------------------------------------------------
// lfsr32
//   32-bit Galois LFSR used as the BIST operand source.
//   clk, rst_n : clock, asynchronous active-low reset
//   load, seed : load seed into the state (has priority over step)
//   step       : advance the state by two positions (one operand pair)
//   state      : current state (operand A)
//   state_nxt  : one-step look-ahead of state (operand B)
// ----------------------------------------------------------------------------
module lfsr32
   import dsp_addsub_bist_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] seed,
   input  logic        step,
   output logic [31:0] state,
   output logic [31:0] state_nxt
);

   assign state_nxt = lfsr_step(state);

   // Reset to a non-zero value so the register can never lock up at zero
   // even if stepped before the first seed load.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= 32'h0000_0001;
      end else if (load) begin
         state <= seed;
      end else if (step) begin
         state <= lfsr_step(state_nxt);
      end
   end

endmodule

// File: rtl/dsp_addsub_bist.sv
// ----------------------------------------------------------------------------
// dsp_addsub_bist
//   Self-test sequencer for dsp_add_sub: applies 4 directed vectors followed
//   by LFSR pseudo-random vectors, checks each result against a modulo-2^32
//   golden model, and reports on one LED (steady = pass, blink = fail).
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : one-cycle pulse, starts a run from IDLE or DONE
//   dut_input1/2        : operands A / B to dsp_add_sub
//   dut_add_sub         : 0 = A+B, 1 = A-B
//   dut_out             : result from dsp_add_sub
//   busy / done / pass  : run status; pass valid while done
//   fail_count          : saturating mismatch count of the last run
//   first_fail_idx      : first mismatching vector index, 16'hFFFF if none
//   led                 : status indicator
// ----------------------------------------------------------------------------
module dsp_addsub_bist
   import dsp_addsub_bist_pkg::*;
#(
   parameter int          NUM_VECTORS   = 256,
   parameter int          SETTLE_CYCLES = 2,
   parameter logic [31:0] LFSR_SEED     = 32'hACE1_2024,
   parameter int          BLINK_DIV     = 12000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [31:0] dut_input1,
   output logic [31:0] dut_input2,
   output logic        dut_add_sub,
   input  logic [31:0] dut_out,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] fail_count,
   output logic [15:0] first_fail_idx,
   output logic        led
);

   localparam logic [15:0] LAST_IDX    = 16'(NUM_VECTORS - 1);
   localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [31:0] BLINK_LAST  = 32'(BLINK_DIV - 1);

   state_t      state, state_nxt;
   logic [15:0] idx;
   logic [3:0]  settle_cnt;
   logic [31:0] blink_cnt;
   logic        blink_led;

   logic        start_ok;
   logic        last_vec;
   logic        settle_last;
   logic [31:0] expected;
   logic        mismatch;
   logic [15:0] fail_count_upd;
   vec_t        vec;

   logic [31:0] lfsr_state;
   logic [31:0] lfsr_next;

   // start is only honoured when no run is in progress.
   assign start_ok    = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign last_vec    = (idx == LAST_IDX);
   assign settle_last = (settle_cnt == SETTLE_LAST);

   lfsr32 u_lfsr (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (start_ok),
      .seed      (LFSR_SEED),
      .step      ((state == ST_DRIVE) && (idx > 16'd3)),
      .state     (lfsr_state),
      .state_nxt (lfsr_next)
   );

   // Golden model: the held dut_* registers are exactly what the block sees.
   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      expected = dut_input1 + dut_input2;
      if (dut_add_sub == OP_SUB) begin
         expected = dut_input1 - dut_input2;
      end
      mismatch       = (dut_out != expected);
      fail_count_upd = fail_count;
      if (mismatch && (fail_count != 16'hFFFF)) begin
         fail_count_upd = fail_count + 16'd1;
      end
   end

   always_comb begin
      vec = '{a: lfsr_state, b: lfsr_next, op: idx[0]};
      if (idx < 16'd4) begin
         vec = directed_vec(idx[1:0]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (start_ok) state_nxt = ST_DRIVE;
         ST_DRIVE:  state_nxt = ST_SETTLE;
         ST_SETTLE: if (settle_last) state_nxt = ST_CHECK;
         ST_CHECK:  state_nxt = last_vec ? ST_DONE : ST_DRIVE;
         ST_DONE:   if (start_ok) state_nxt = ST_DRIVE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dut_input1     <= '0;
         dut_input2     <= '0;
         dut_add_sub    <= OP_ADD;
         idx            <= '0;
         settle_cnt     <= '0;
         fail_count     <= '0;
         first_fail_idx <= 16'hFFFF;
         pass           <= 1'b0;
         blink_cnt      <= '0;
         blink_led      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start_ok) begin
                  idx            <= '0;
                  settle_cnt     <= '0;
                  fail_count     <= '0;
                  first_fail_idx <= 16'hFFFF;
                  pass           <= 1'b0;
               end else if (state == ST_DONE) begin
                  if (blink_cnt == BLINK_LAST) begin
                     blink_cnt <= '0;
                     blink_led <= ~blink_led;
                  end else begin
                     blink_cnt <= blink_cnt + 32'd1;
                  end
               end
            end
            ST_DRIVE: begin
               dut_input1  <= vec.a;
               dut_input2  <= vec.b;
               dut_add_sub <= vec.op;
               settle_cnt  <= '0;
            end
            ST_SETTLE: begin
               if (!settle_last) begin
                  settle_cnt <= settle_cnt + 4'd1;
               end
            end
            ST_CHECK: begin
               fail_count <= fail_count_upd;
               // fail_count still zero means this is the first mismatch.
               if (mismatch && (fail_count == 16'd0)) begin
                  first_fail_idx <= idx;
               end
               if (last_vec) begin
                  pass      <= (fail_count_upd == 16'd0);
                  blink_cnt <= '0;
                  blink_led <= 1'b1;
               end else begin
                  idx <= idx + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state == ST_DRIVE) || (state == ST_SETTLE) || (state == ST_CHECK);
   assign done = (state == ST_DONE);

   always_comb begin
      led = 1'b1;
      case (state)
         ST_IDLE: led = 1'b0;
         ST_DONE: led = pass ? 1'b1 : blink_led;
         default: led = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_dsp_addsub_bist.sv
// ----------------------------------------------------------------------------
// tb_dsp_addsub_bist
//   Directed bench for dsp_addsub_bist. Two instances: a 16-vector run with
//   SETTLE_CYCLES = 2 and BLINK_DIV = 8 against a behavioural adder with an
//   optional bit-0 stuck-at-0 fault, and a 4-vector SETTLE_CYCLES = 1 run
//   against a one-cycle registered adder.
// ----------------------------------------------------------------------------
module tb_dsp_addsub_bist;

   localparam logic [31:0] SEED = 32'hACE1_2024;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- main instance ----------------
   logic        start = 1'b0;
   logic [31:0] in1, in2, dout;
   logic        add_sub, busy, done, pass, led;
   logic [15:0] fail_count, first_fail_idx;
   logic        fault_bit0 = 1'b0;

   always_comb begin
      dout = add_sub ? (in1 - in2) : (in1 + in2);
      if (fault_bit0) dout[0] = 1'b0;
   end

   dsp_addsub_bist #(
      .NUM_VECTORS(16), .SETTLE_CYCLES(2), .LFSR_SEED(SEED), .BLINK_DIV(8)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .dut_input1(in1), .dut_input2(in2), .dut_add_sub(add_sub), .dut_out(dout),
      .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
      .first_fail_idx(first_fail_idx), .led(led)
   );

   // ---------------- SETTLE_CYCLES = 1 instance ----------------
   logic        start_s1 = 1'b0;
   logic [31:0] s1_in1, s1_in2, s1_out;
   logic        s1_add_sub, s1_busy, s1_done, s1_pass, s1_led;
   logic [15:0] s1_fail_count, s1_first_fail_idx;

   // One cycle of latency: only correct if sampled two cycles after DRIVE.
   always @(posedge clk) s1_out <= s1_add_sub ? (s1_in1 - s1_in2) : (s1_in1 + s1_in2);

   dsp_addsub_bist #(
      .NUM_VECTORS(4), .SETTLE_CYCLES(1), .LFSR_SEED(SEED), .BLINK_DIV(8)
   ) u_dut_s1 (
      .clk(clk), .rst_n(rst_n), .start(start_s1),
      .dut_input1(s1_in1), .dut_input2(s1_in2), .dut_add_sub(s1_add_sub), .dut_out(s1_out),
      .busy(s1_busy), .done(s1_done), .pass(s1_pass), .fail_count(s1_fail_count),
      .first_fail_idx(s1_first_fail_idx), .led(s1_led)
   );

   // ---------------- reference vectors ----------------
   logic [31:0] exp_a [16];
   logic [31:0] exp_b [16];
   logic        exp_op [16];
   logic [31:0] exp_res [16];

   logic [31:0] got_a [16];
   logic [31:0] got_b [16];
   logic        got_op [16];
   logic        led_hist [80];
   logic        done_hist [80];
   int          busy_cnt;

   function automatic logic [31:0] ref_lfsr(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
   endfunction

   task automatic build_expected();
      logic [31:0] s;
      exp_a[0] = 32'hFFFF_FFFF; exp_b[0] = 32'h0000_0001; exp_op[0] = 1'b0;
      exp_a[1] = 32'h0000_0000; exp_b[1] = 32'h0000_0001; exp_op[1] = 1'b1;
      exp_a[2] = 32'h7FFF_FFFF; exp_b[2] = 32'h0000_0001; exp_op[2] = 1'b0;
      exp_a[3] = 32'hFFFF_FFFF; exp_b[3] = 32'hFFFF_FFFF; exp_op[3] = 1'b1;
      s = SEED;
      for (int k = 4; k < 16; k++) begin
         exp_a[k]  = s;
         exp_b[k]  = ref_lfsr(s);
         s         = ref_lfsr(exp_b[k]);
         exp_op[k] = (k % 2 == 1);
      end
      for (int k = 0; k < 16; k++)
         exp_res[k] = exp_op[k] ? (exp_a[k] - exp_b[k]) : (exp_a[k] + exp_b[k]);
   endtask

   // Starts a run on the main instance and records 80 cycles of activity.
   // Vector k is on dut_* from posedge 4k+1 to 4k+5 after the start edge.
   task automatic run_main(input bit spam);
      @(negedge clk) start = 1'b1;
      busy_cnt = 0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         start = spam && (c <= 63) && (c % 3 == 0);
         if (busy) busy_cnt++;
         led_hist[c]  = led;
         done_hist[c] = done;
         if ((c % 4 == 2) && (c / 4 < 16)) begin
            got_a[c / 4]  = in1;
            got_b[c / 4]  = in2;
            got_op[c / 4] = add_sub;
         end
      end
      start = 1'b0;
   endtask

   task automatic compare_vectors(input string tag);
      for (int k = 0; k < 16; k++) begin
         n_checks++;
         if (got_a[k] !== exp_a[k] || got_b[k] !== exp_b[k] || got_op[k] !== exp_op[k]) begin
            n_fail++;
            $display("FAIL %s vec%0d: got %h %h op%b, want %h %h op%b", tag, k,
                     got_a[k], got_b[k], got_op[k], exp_a[k], exp_b[k], exp_op[k]);
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({busy, done, pass, led} !== 4'b0000 || fail_count !== 16'h0 ||
          first_fail_idx !== 16'hFFFF || {in1, in2, add_sub} !== 65'h0) begin
         n_fail++;
         $display("FAIL reset_state: busy%b done%b pass%b led%b fc=%h ffi=%h in=%h/%h/%b",
                  busy, done, pass, led, fail_count, first_fail_idx, in1, in2, add_sub);
      end
      n_checks++;
      if ({s1_busy, s1_done, s1_pass, s1_led} !== 4'b0000 || s1_first_fail_idx !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL reset_state_s1: flags %b ffi=%h, want 0000 ffff",
                  {s1_busy, s1_done, s1_pass, s1_led}, s1_first_fail_idx);
      end
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_pass_run();
      int led_bad = 0;
      run_main(1'b0);
      for (int c = 64; c < 80; c++) if (led_hist[c] !== 1'b1) led_bad++;
      n_checks++;
      if (busy_cnt != 64) begin
         n_fail++; $display("FAIL pass_busy_len: got %0d, want 64", busy_cnt);
      end
      n_checks++;
      if ({done, pass} !== 2'b11 || fail_count !== 16'd0 || first_fail_idx !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL pass_result: done%b pass%b fc=%h ffi=%h, want 1 1 0000 ffff",
                  done, pass, fail_count, first_fail_idx);
      end
      n_checks++;
      if (led_bad != 0) begin
         n_fail++; $display("FAIL pass_led_steady: %0d low samples, want 0", led_bad);
      end
      compare_vectors("pass_vectors");
   endtask

   task automatic test_fault_and_blink();
      int exp_fc = 0;
      for (int k = 0; k < 16; k++) if (exp_res[k][0]) exp_fc++;
      fault_bit0 = 1'b1;
      run_main(1'b0);
      n_checks++;
      if ({done, pass} !== 2'b10 || first_fail_idx !== 16'd1) begin
         n_fail++;
         $display("FAIL fault_result: done%b pass%b ffi=%h, want 1 0 0001", done, pass, first_fail_idx);
      end
      n_checks++;
      if (fail_count !== 16'(exp_fc) || fail_count == 16'd0) begin
         n_fail++; $display("FAIL fault_count: got %0d, want %0d", fail_count, exp_fc);
      end
      // DONE entered at sample 64: 8 on, 8 off, then 8 on again.
      for (int c = 64; c < 80; c++) begin
         n_checks++;
         if (led_hist[c] !== (c < 72)) begin
            n_fail++; $display("FAIL blink_c%0d: led %b, want %b", c, led_hist[c], c < 72);
         end
      end
      for (int c = 80; c < 88; c++) begin
         @(negedge clk);
         n_checks++;
         if (led !== 1'b1) begin
            n_fail++; $display("FAIL blink_c%0d: led %b, want 1", c, led);
         end
      end
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      n_checks++;
      if ({led, busy, done} !== 3'b110) begin
         n_fail++; $display("FAIL restart_from_fail: led%b busy%b done%b, want 1 1 0", led, busy, done);
      end
      fault_bit0 = 1'b0;
      repeat (70) @(negedge clk);
      n_checks++;
      if ({done, pass} !== 2'b11) begin
         n_fail++; $display("FAIL restart_pass: done%b pass%b, want 1 1", done, pass);
      end
   endtask

   task automatic test_reset_midrun();
      @(negedge clk) start = 1'b1;
      @(posedge clk);           // start captured here (edge 0)
      #1 start = 1'b0;
      repeat (21) @(posedge clk);  // now in first SETTLE cycle of vector 5
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, pass, led} !== 4'b0000 || fail_count !== 16'h0 ||
          first_fail_idx !== 16'hFFFF || {in1, in2, add_sub} !== 65'h0) begin
         n_fail++;
         $display("FAIL midrun_reset: busy%b done%b pass%b led%b fc=%h ffi=%h in=%h/%h",
                  busy, done, pass, led, fail_count, first_fail_idx, in1, in2);
      end
      @(negedge clk) rst_n = 1'b1;
      run_main(1'b0);
      compare_vectors("rerun_vectors");
      n_checks++;
      if (busy_cnt != 64 || {done, pass} !== 2'b11) begin
         n_fail++; $display("FAIL rerun_result: busy %0d done%b pass%b, want 64 1 1", busy_cnt, done, pass);
      end
   endtask

   task automatic test_start_while_busy();
      run_main(1'b1);
      n_checks++;
      if (busy_cnt != 64) begin
         n_fail++; $display("FAIL spam_busy_len: got %0d, want 64", busy_cnt);
      end
      n_checks++;
      if (done_hist[63] !== 1'b0 || done_hist[64] !== 1'b1 || done_hist[79] !== 1'b1) begin
         n_fail++;
         $display("FAIL spam_done_entry: done@63=%b @64=%b @79=%b, want 0 1 1",
                  done_hist[63], done_hist[64], done_hist[79]);
      end
      n_checks++;
      if (pass !== 1'b1 || fail_count !== 16'd0 || first_fail_idx !== 16'hFFFF) begin
         n_fail++; $display("FAIL spam_result: pass%b fc=%h ffi=%h", pass, fail_count, first_fail_idx);
      end
      compare_vectors("spam_vectors");
   endtask

   task automatic test_settle_one();
      logic [31:0] want_res [4];
      int          s1_busy_cnt = 0;
      want_res[0] = 32'h0000_0000; want_res[1] = 32'hFFFF_FFFF;
      want_res[2] = 32'h8000_0000; want_res[3] = 32'h0000_0000;
      @(negedge clk) start_s1 = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         start_s1 = 1'b0;
         if (s1_busy) s1_busy_cnt++;
         if ((c % 3 == 1) && (c / 3 < 4)) begin
            n_checks++;
            if (s1_in1 !== exp_a[c / 3] || s1_in2 !== exp_b[c / 3] || s1_add_sub !== exp_op[c / 3]) begin
               n_fail++;
               $display("FAIL s1_vec%0d: got %h %h op%b, want %h %h op%b", c / 3,
                        s1_in1, s1_in2, s1_add_sub, exp_a[c / 3], exp_b[c / 3], exp_op[c / 3]);
            end
         end
         if ((c % 3 == 2) && (c / 3 < 4)) begin
            n_checks++;
            if (s1_out !== want_res[c / 3]) begin
               n_fail++; $display("FAIL s1_res%0d: got %h, want %h", c / 3, s1_out, want_res[c / 3]);
            end
         end
      end
      n_checks++;
      if (s1_busy_cnt != 12) begin
         n_fail++; $display("FAIL s1_busy_len: got %0d, want 12", s1_busy_cnt);
      end
      n_checks++;
      if ({s1_done, s1_pass, s1_led} !== 3'b111 || s1_fail_count !== 16'd0 ||
          s1_first_fail_idx !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL s1_result: done%b pass%b led%b fc=%h ffi=%h, want 1 1 1 0000 ffff",
                  s1_done, s1_pass, s1_led, s1_fail_count, s1_first_fail_idx);
      end
   endtask

   initial begin
      build_expected();
      test_reset();
      test_pass_run();
      test_fault_and_blink();
      test_reset_midrun();
      test_start_while_busy();
      test_settle_one();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
